// File: rtl/branch_pc_unit_if.sv
// EX-stage branch/jump control bundle between the pipeline and branch_pc_unit.
// The pipeline side (master) drives the i_* signals; the unit (slave) drives the o_* signals.
interface branch_pc_unit_if #(
    parameter int unsigned CNT_W = 16
);
    logic             i_stall;
    logic             i_is_branch;
    logic             i_is_jal;
    logic             i_is_jalr;
    logic [2:0]       i_funct3;
    logic             i_br_less;
    logic             i_br_equal;
    logic [31:0]      i_pc_ex;
    logic [31:0]      i_imm;
    logic [31:0]      i_rs1_data;

    logic             o_br_un;
    logic [31:0]      o_pc;
    logic [31:0]      o_pc_four;
    logic             o_taken;
    logic             o_flush;
    logic             o_misaligned;
    logic [CNT_W-1:0] o_br_total;
    logic [CNT_W-1:0] o_br_taken;

    modport master (
        output i_stall, i_is_branch, i_is_jal, i_is_jalr, i_funct3,
               i_br_less, i_br_equal, i_pc_ex, i_imm, i_rs1_data,
        input  o_br_un, o_pc, o_pc_four, o_taken, o_flush, o_misaligned,
               o_br_total, o_br_taken
    );

    modport slave (
        input  i_stall, i_is_branch, i_is_jal, i_is_jalr, i_funct3,
               i_br_less, i_br_equal, i_pc_ex, i_imm, i_rs1_data,
        output o_br_un, o_pc, o_pc_four, o_taken, o_flush, o_misaligned,
               o_br_total, o_br_taken
    );
endinterface

// File: rtl/branch_pc_unit.sv
// RV32I branch resolution and fetch PC register: decides taken/not-taken, redirects
// fetch, flushes IF/ID, counts conditional branches and traps on misaligned targets.
module branch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    branch_pc_unit_if.slave bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] tot_q, tot_d;
    logic [CNT_W-1:0] tkn_q, tkn_d;
    logic             mis_q, mis_d;

    logic             br_cond;
    logic             branch_wins;
    logic             redirect_cond;
    logic [31:0]      rel_sum;
    logic [31:0]      jalr_sum;
    logic [31:0]      target;
    logic [31:0]      pc_plus4;
    logic             taken;
    logic             flush;

    always_comb begin
        br_cond = 1'b0;
        case (bus.i_funct3)
            3'b000:         br_cond = bus.i_br_equal;
            3'b001:         br_cond = !bus.i_br_equal;
            3'b100, 3'b110: br_cond = bus.i_br_less;
            3'b101, 3'b111: br_cond = !bus.i_br_less;
            default:        br_cond = 1'b0;
        endcase
    end

    // JALR outranks JAL, which outranks a conditional branch
    assign branch_wins   = bus.i_is_branch && !bus.i_is_jal && !bus.i_is_jalr;
    assign redirect_cond = bus.i_is_jalr || bus.i_is_jal || (bus.i_is_branch && br_cond);

    assign rel_sum  = bus.i_pc_ex + bus.i_imm;
    assign jalr_sum = bus.i_rs1_data + bus.i_imm;
    assign target   = bus.i_is_jalr ? (jalr_sum & 32'hFFFF_FFFE) : rel_sum;
    assign pc_plus4 = pc_q + 32'd4;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            tot_q   <= '0;
            tkn_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tot_q   <= tot_d;
            tkn_q   <= tkn_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tot_d   = tot_q;
        tkn_d   = tkn_q;
        mis_d   = mis_q;
        taken   = 1'b0;
        flush   = 1'b0;
        case (state_q)
            RUN: begin
                if (!bus.i_stall) begin
                    if (branch_wins) begin
                        tot_d = tot_q + CNT_W'(1);
                        if (br_cond) begin
                            tkn_d = tkn_q + CNT_W'(1);
                        end
                    end
                    if (redirect_cond) begin
                        taken = 1'b1;
                        flush = 1'b1;
                        if (target[1:0] == 2'b00) begin
                            pc_d    = target;
                            state_d = REDIRECT;
                        end else begin
                            // trap: PC holds at the faulting fetch address
                            mis_d   = 1'b1;
                            state_d = HALT;
                        end
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            REDIRECT: begin
                // EX holds the flush bubble here, so its controls are not looked at
                if (!bus.i_stall) begin
                    pc_d    = pc_plus4;
                    state_d = RUN;
                end
            end
            HALT: begin
                flush = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign bus.o_br_un      = bus.i_funct3[1];
    assign bus.o_pc         = pc_q;
    assign bus.o_pc_four    = pc_plus4;
    assign bus.o_taken      = taken;
    assign bus.o_flush      = flush;
    assign bus.o_misaligned = mis_q;
    assign bus.o_br_total   = tot_q;
    assign bus.o_br_taken   = tkn_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: expected vectors are queued per driven cycle
// and popped against the sampled outputs once the cycle completes.
module tb_branch_pc_unit;

    localparam int unsigned CW  = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b0;
    always #5 i_clk = ~i_clk;

    branch_pc_unit_if #(.CNT_W(CW)) bus ();

    branch_pc_unit #(
        .RESET_PC(RPC),
        .CNT_W   (CW)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (bus)
    );

    // {br_un, taken, flush, misaligned, pc, br_total, br_taken}
    typedef struct {
        string       tag;
        logic [43:0] v;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_pc;
    logic [3:0]  m_tot;
    logic [3:0]  m_tkn;

    function automatic logic [43:0] pk(input logic bu, input logic tk, input logic fl,
                                       input logic mis, input logic [31:0] pc,
                                       input logic [3:0] t, input logic [3:0] k);
        return {bu, tk, fl, mis, pc, t, k};
    endfunction

    task automatic drive(input logic br, input logic jal, input logic jalr,
                         input logic [2:0] f3, input logic less, input logic eq,
                         input logic [31:0] pcx, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic stall);
        bus.i_is_branch = br;
        bus.i_is_jal    = jal;
        bus.i_is_jalr   = jalr;
        bus.i_funct3    = f3;
        bus.i_br_less   = less;
        bus.i_br_equal  = eq;
        bus.i_pc_ex     = pcx;
        bus.i_imm       = imm;
        bus.i_rs1_data  = rs1;
        bus.i_stall     = stall;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    // combinational outputs sampled before the edge, registered ones just after it
    task automatic run_cycle(output logic [43:0] obs);
        logic bu, tk, fl;
        #1;
        bu = bus.o_br_un;
        tk = bus.o_taken;
        fl = bus.o_flush;
        @(posedge i_clk);
        #1;
        obs = {bu, tk, fl, bus.o_misaligned, bus.o_pc, bus.o_br_total, bus.o_br_taken};
    endtask

    task automatic test_reset();
        logic [43:0] obs;
        exp_t        e;
        i_reset = 1'b0;
        idle();
        repeat (2) @(posedge i_clk);
        #1;
        sb.push_back('{"reset_state", pk(1'b0, 1'b0, 1'b0, 1'b0, RPC, 4'd0, 4'd0)});
        obs = {bus.o_br_un, bus.o_taken, bus.o_flush, bus.o_misaligned, bus.o_pc,
               bus.o_br_total, bus.o_br_taken};
        e = sb.pop_front();
        total++;
        if (obs !== e.v) begin
            bad++;
            $display("FAIL %s got=%h want=%h", e.tag, obs, e.v);
        end
        total++;
        if (bus.o_pc_four !== RPC + 32'd4) begin
            bad++;
            $display("FAIL reset_pc_four got=%h want=%h", bus.o_pc_four, RPC + 32'd4);
        end
        @(negedge i_clk);
        i_reset = 1'b1;
        m_pc  = RPC;
        m_tot = 4'd0;
        m_tkn = 4'd0;
    endtask

    task automatic test_free_run();
        logic [43:0] obs;
        exp_t        e;
        for (int i = 0; i < 8; i++) begin
            idle();
            m_pc = m_pc + 32'd4;
            sb.push_back('{$sformatf("free_run_%0d", i), pk(1'b0, 1'b0, 1'b0, 1'b0, m_pc, m_tot, m_tkn)});
            run_cycle(obs);
            e = sb.pop_front();
            total++;
            if (obs !== e.v) begin
                bad++;
                $display("FAIL %s got=%h want=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic test_beq_taken();
        logic [43:0] obs;
        exp_t        e;
        drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 32'h18, 32'h40, 32'h0, 1'b0);
        m_tot++;
        m_tkn++;
        m_pc = 32'h58;
        sb.push_back('{"beq_taken", pk(1'b0, 1'b1, 1'b1, 1'b0, m_pc, m_tot, m_tkn)});
        // taken-looking BLTU during REDIRECT must be ignored
        for (int i = 0; i < 2; i++) begin
            if (i == 1) begin
                drive(1'b1, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0, 32'h18, 32'h40, 32'h0, 1'b0);
                m_pc = m_pc + 32'd4;
                sb.push_back('{"beq_redirect_ignore", pk(1'b1, 1'b0, 1'b0, 1'b0, m_pc, m_tot, m_tkn)});
            end
            run_cycle(obs);
            e = sb.pop_front();
            total++;
            if (obs !== e.v) begin
                bad++;
                $display("FAIL %s got=%h want=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic test_bgeu_not_taken();
        logic [43:0] obs;
        exp_t        e;
        drive(1'b1, 1'b0, 1'b0, 3'b111, 1'b1, 1'b0, m_pc, 32'h40, 32'h0, 1'b0);
        m_tot++;
        m_pc = m_pc + 32'd4;
        sb.push_back('{"bgeu_not_taken", pk(1'b1, 1'b0, 1'b0, 1'b0, m_pc, m_tot, m_tkn)});
        run_cycle(obs);
        e = sb.pop_front();
        total++;
        if (obs !== e.v) begin
            bad++;
            $display("FAIL %s got=%h want=%h", e.tag, obs, e.v);
        end
    endtask

    task automatic test_cond_decode();
        // {funct3, less, equal, expect_taken}
        logic [5:0]  tbl[10] = '{6'b000_0_0_0, 6'b001_0_0_1, 6'b001_0_1_0, 6'b100_1_0_1,
                                 6'b100_0_1_0, 6'b101_0_0_1, 6'b110_0_0_0, 6'b111_0_1_1,
                                 6'b010_1_1_0, 6'b011_0_1_0};
        logic [43:0] obs;
        exp_t        e;
        logic [5:0]  row;
        logic [31:0] tgt;
        for (int i = 0; i < 10; i++) begin
            row = tbl[i];
            drive(1'b1, 1'b0, 1'b0, row[5:3], row[2], row[1], m_pc, 32'h80, 32'h0, 1'b0);
            m_tot++;
            if (row[0]) begin
                m_tkn++;
                tgt  = m_pc + 32'h80;
                m_pc = tgt;
                sb.push_back('{$sformatf("cond_%0d_taken", i), pk(row[4], 1'b1, 1'b1, 1'b0, m_pc, m_tot, m_tkn)});
            end else begin
                m_pc = m_pc + 32'd4;
                sb.push_back('{$sformatf("cond_%0d_not", i), pk(row[4], 1'b0, 1'b0, 1'b0, m_pc, m_tot, m_tkn)});
            end
            run_cycle(obs);
            e = sb.pop_front();
            total++;
            if (obs !== e.v) begin
                bad++;
                $display("FAIL %s got=%h want=%h", e.tag, obs, e.v);
            end
            if (row[0]) begin
                idle();
                m_pc = m_pc + 32'd4;
                sb.push_back('{$sformatf("cond_%0d_redirect", i), pk(1'b0, 1'b0, 1'b0, 1'b0, m_pc, m_tot, m_tkn)});
                run_cycle(obs);
                e = sb.pop_front();
                total++;
                if (obs !== e.v) begin
                    bad++;
                    $display("FAIL %s got=%h want=%h", e.tag, obs, e.v);
                end
            end
        end
    endtask

    task automatic test_priority();
        logic [43:0] obs;
        exp_t        e;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: begin
                    // JAL beats a taken-looking branch: no counter update
                    drive(1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 32'h300, 32'h10, 32'h0, 1'b0);
                    m_pc = 32'h310;
                    sb.push_back('{"prio_jal_over_br", pk(1'b0, 1'b1, 1'b1, 1'b0, m_pc, m_tot, m_tkn)});
                end
                2: begin
                    drive(1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 1'b1, 32'h400, 32'h8, 32'h2000, 1'b0);
                    m_pc = 32'h2008;
                    sb.push_back('{"prio_jalr_over_jal", pk(1'b0, 1'b1, 1'b1, 1'b0, m_pc, m_tot, m_tkn)});
                end
                default: begin
                    idle();
                    m_pc = m_pc + 32'd4;
                    sb.push_back('{$sformatf("prio_redirect_%0d", i), pk(1'b0, 1'b0, 1'b0, 1'b0, m_pc, m_tot, m_tkn)});
                end
            endcase
            run_cycle(obs);
            e = sb.pop_front();
            total++;
            if (obs !== e.v) begin
                bad++;
                $display("FAIL %s got=%h want=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic test_jalr_stall();
        logic [43:0] obs;
        exp_t        e;
        logic [31:0] tgt;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0, 1: begin
                    drive(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h50, 32'h4, 32'h1001, 1'b1);
                    sb.push_back('{$sformatf("jalr_stalled_%0d", i), pk(1'b0, 1'b0, 1'b0, 1'b0, m_pc, m_tot, m_tkn)});
                end
                2: begin
                    drive(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h50, 32'h4, 32'h1001, 1'b0);
                    m_pc = 32'h1004;
                    sb.push_back('{"jalr_lsb_clear", pk(1'b0, 1'b1, 1'b1, 1'b0, m_pc, m_tot, m_tkn)});
                end
                3: begin
                    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
                    sb.push_back('{"redirect_stalled", pk(1'b0, 1'b0, 1'b0, 1'b0, m_pc, m_tot, m_tkn)});
                end
                4: begin
                    drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h100, 32'h0, 1'b0);
                    m_pc = m_pc + 32'd4;
                    sb.push_back('{"redirect_jal_ignored", pk(1'b0, 1'b0, 1'b0, 1'b0, m_pc, m_tot, m_tkn)});
                end
                5: begin
                    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, m_pc, 32'h20, 32'h0, 1'b1);
                    sb.push_back('{"stall_beats_branch", pk(1'b0, 1'b0, 1'b0, 1'b0, m_pc, m_tot, m_tkn)});
                end
                6: begin
                    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, m_pc, 32'h20, 32'h0, 1'b0);
                    tgt  = m_pc + 32'h20;
                    m_pc = tgt;
                    m_tot++;
                    m_tkn++;
                    sb.push_back('{"branch_after_stall", pk(1'b0, 1'b1, 1'b1, 1'b0, m_pc, m_tot, m_tkn)});
                end
                default: begin
                    idle();
                    m_pc = m_pc + 32'd4;
                    sb.push_back('{"stall_redirect_done", pk(1'b0, 1'b0, 1'b0, 1'b0, m_pc, m_tot, m_tkn)});
                end
            endcase
            run_cycle(obs);
            e = sb.pop_front();
            total++;
            if (obs !== e.v) begin
                bad++;
                $display("FAIL %s got=%h want=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic test_pc_wrap();
        logic [43:0] obs;
        exp_t        e;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin
                drive(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFF8, 1'b0);
                m_pc = 32'hFFFF_FFF8;
                sb.push_back('{"wrap_jump", pk(1'b0, 1'b1, 1'b1, 1'b0, m_pc, m_tot, m_tkn)});
            end else begin
                idle();
                m_pc = m_pc + 32'd4;
                sb.push_back('{$sformatf("wrap_step_%0d", i), pk(1'b0, 1'b0, 1'b0, 1'b0, m_pc, m_tot, m_tkn)});
            end
            run_cycle(obs);
            e = sb.pop_front();
            total++;
            if (obs !== e.v) begin
                bad++;
                $display("FAIL %s got=%h want=%h", e.tag, obs, e.v);
            end
            if (i == 1) begin
                total++;
                if (bus.o_pc_four !== 32'h0) begin
                    bad++;
                    $display("FAIL wrap_pc_four got=%h want=%h", bus.o_pc_four, 32'h0);
                end
            end
        end
    endtask

    task automatic test_counter_wrap();
        logic [43:0] obs;
        exp_t        e;
        idle();
        i_reset = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b1;
        m_pc  = RPC;
        m_tot = 4'd0;
        m_tkn = 4'd0;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, m_pc, 32'h10, 32'h0, 1'b0);
            m_pc = m_pc + 32'h10;
            m_tot++;
            m_tkn++;
            sb.push_back('{$sformatf("cwrap_bne_%0d", i), pk(1'b0, 1'b1, 1'b1, 1'b0, m_pc, m_tot, m_tkn)});
            run_cycle(obs);
            e = sb.pop_front();
            total++;
            if (obs !== e.v) begin
                bad++;
                $display("FAIL %s got=%h want=%h", e.tag, obs, e.v);
            end
            idle();
            m_pc = m_pc + 32'd4;
            sb.push_back('{$sformatf("cwrap_redir_%0d", i), pk(1'b0, 1'b0, 1'b0, 1'b0, m_pc, m_tot, m_tkn)});
            run_cycle(obs);
            e = sb.pop_front();
            total++;
            if (obs !== e.v) begin
                bad++;
                $display("FAIL %s got=%h want=%h", e.tag, obs, e.v);
            end
        end
        total++;
        if ({bus.o_br_total, bus.o_br_taken} !== {4'd1, 4'd1}) begin
            bad++;
            $display("FAIL cwrap_final got=%h/%h want=1/1", bus.o_br_total, bus.o_br_taken);
        end
    endtask

    task automatic test_misaligned();
        logic [43:0] obs;
        exp_t        e;
        logic [43:0] rs;
        drive(1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 32'h100, 32'h6, 32'h0, 1'b0);
        sb.push_back('{"misaligned_jal", pk(1'b0, 1'b1, 1'b1, 1'b1, m_pc, m_tot, m_tkn)});
        run_cycle(obs);
        e = sb.pop_front();
        total++;
        if (obs !== e.v) begin
            bad++;
            $display("FAIL %s got=%h want=%h", e.tag, obs, e.v);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, (i % 2) == 1, (i % 3) == 0, 3'b000, 1'b0, 1'b1, 32'h200, 32'h40,
                  32'h300, i == 2);
            sb.push_back('{$sformatf("halt_%0d", i), pk(1'b0, 1'b0, 1'b1, 1'b1, m_pc, m_tot, m_tkn)});
            run_cycle(obs);
            e = sb.pop_front();
            total++;
            if (obs !== e.v) begin
                bad++;
                $display("FAIL %s got=%h want=%h", e.tag, obs, e.v);
            end
        end
        // asynchronous reset in the middle of a HALT cycle
        idle();
        #2 i_reset = 1'b0;
        #1;
        rs = {bus.o_br_un, bus.o_taken, bus.o_flush, bus.o_misaligned, bus.o_pc,
              bus.o_br_total, bus.o_br_taken};
        total++;
        if (rs !== pk(1'b0, 1'b0, 1'b0, 1'b0, RPC, 4'd0, 4'd0)) begin
            bad++;
            $display("FAIL halt_reset got=%h want=%h", rs, pk(1'b0, 1'b0, 1'b0, 1'b0, RPC, 4'd0, 4'd0));
        end
        @(negedge i_clk);
        i_reset = 1'b1;
        m_pc  = RPC;
        m_tot = 4'd0;
        m_tkn = 4'd0;
        // misaligned taken branch still counts
        drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 32'h10, 32'h2, 32'h0, 1'b0);
        m_tot++;
        m_tkn++;
        sb.push_back('{"misaligned_beq", pk(1'b0, 1'b1, 1'b1, 1'b1, m_pc, m_tot, m_tkn)});
        run_cycle(obs);
        e = sb.pop_front();
        total++;
        if (obs !== e.v) begin
            bad++;
            $display("FAIL %s got=%h want=%h", e.tag, obs, e.v);
        end
        idle();
        sb.push_back('{"misaligned_beq_halt", pk(1'b0, 1'b0, 1'b1, 1'b1, m_pc, m_tot, m_tkn)});
        run_cycle(obs);
        e = sb.pop_front();
        total++;
        if (obs !== e.v) begin
            bad++;
            $display("FAIL %s got=%h want=%h", e.tag, obs, e.v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_run();
        test_beq_taken();
        test_bgeu_not_taken();
        test_cond_decode();
        test_priority();
        test_jalr_stall();
        test_pc_wrap();
        test_counter_wrap();
        test_misaligned();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Branch-resolution and program-counter stage sitting directly downstream of the branch comparator in the EX stage of the RV32I pipeline. Takes the comparator's `less`/`equal` flags together with the decoded branch/jump controls and decides taken/not-taken. Owns the fetch PC register and drives the IF/ID flush. Also keeps per-run branch statistics and traps on misaligned control-flow targets.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `CNT_W`, default `16`: width of the statistics counters.

Ports:
- `i_clk`  in  1  single clock; all state updates on the rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_stall`  in  1  pipeline stall. When high: PC, FSM and counters hold, and no redirect occurs.
- `i_is_branch`  in  1  EX instruction is a conditional branch.
- `i_is_jal`  in  1  EX instruction is JAL.
- `i_is_jalr`  in  1  EX instruction is JALR.
- `i_funct3`  in  3  branch funct3 of the EX instruction.
- `i_br_less`  in  1  comparator less flag.
- `i_br_equal`  in  1  comparator equal flag.
- `i_pc_ex`  in  32  PC of the EX instruction.
- `i_imm`  in  32  sign-extended immediate of the EX instruction.
- `i_rs1_data`  in  32  rs1 operand, used for JALR.
- `o_br_un`  out  1  comparator unsigned select. Combinational: `i_funct3[1]`.
- `o_pc`  out  32  fetch PC (registered).
- `o_pc_four`  out  32  `o_pc + 4`, combinational.
- `o_taken`  out  1  redirect decided this cycle (combinational).
- `o_flush`  out  1  squash IF/ID.
- `o_misaligned`  out  1  sticky instruction-address-misaligned trap.
- `o_br_total`  out  CNT_W  count of resolved conditional branches.
- `o_br_taken`  out  CNT_W  count of taken conditional branches.

## Operation
- **Condition decode** (used only when `i_is_branch` is high):
  - `000` BEQ: taken on `equal`.
  - `001` BNE: taken on `!equal`.
  - `100` BLT and `110` BLTU: taken on `less`.
  - `101` BGE and `111` BGEU: taken on `!less`.
  - `010` and `011`: never taken; these are still counted in `o_br_total`.
- **Jump priority**: `i_is_jalr` > `i_is_jal` > `i_is_branch`. JAL and JALR are always taken.
- **Target computation** (32-bit modulo wrap):
  - Branch/JAL: `i_pc_ex + i_imm`.
  - JALR: `(i_rs1_data + i_imm) & ~32'h1`.
- **FSM states**: RUN, REDIRECT, HALT.
- **RUN**:
  - `o_taken = redirect_cond & !i_stall`.
  - `o_taken` with `target[1:0] == 0`: `o_flush = 1` this cycle; next `o_pc = target`; go to REDIRECT.
  - `o_taken` with `target[1:0] != 0`: `o_flush = 1`; set `o_misaligned`; PC holds; go to HALT.
  - Otherwise, if not stalled: `o_pc <= o_pc + 4`.
- **REDIRECT** (exactly one cycle, or longer while stalled):
  - EX holds the bubble created by the flush, so all branch/jump inputs are ignored.
  - `o_taken = 0`, `o_flush = 0`.
  - PC advances by 4 unless stalled; then return to RUN.
- **HALT**:
  - Terminal until reset.
  - `o_pc` frozen, `o_flush = 1` continuously, `o_misaligned = 1`, counters frozen, all inputs ignored.
- **Counters**:
  - Increment only in RUN, when not stalled and `i_is_branch` is the winning control.
  - `o_br_total` increments on every such branch; `o_br_taken` additionally increments if the branch is taken.
  - A misaligned taken branch increments both counters.
  - Both counters wrap at `2^CNT_W`.
- **Stall**: while `i_stall` is high, nothing registered changes and `o_taken`/`o_flush` are 0, except in HALT, where `o_flush` stays 1.

## Timing
- **Reset** (async assert, sync-safe deassert):
  - `o_pc = RESET_PC`, state = RUN, counters = 0, `o_misaligned = 0`.
  - Combinational outputs follow from this: `o_flush = 0`, `o_taken = 0` when no control input is high.
  - Reset mid-REDIRECT or mid-HALT returns to RUN immediately.
- **Redirect latency**: decision and `o_flush` in cycle N (combinational from EX inputs); `o_pc = target` visible from cycle N+1.
- **Branch penalty**: 2 squashed instructions.
- Counters update at the edge ending cycle N and are visible from cycle N+1.
- `o_br_un` has no register stage, so it is valid in the same cycle as `i_funct3`.
- `i_stall` and a taken branch in the same cycle: the stall wins; the branch is re-evaluated when the stall drops.
- PC wrap: `32'hFFFF_FFFC + 4 = 32'h0`. No trap on wrap.

## Test plan
- **Reset then free-run**: release `i_reset`, no controls for 3 cycles → `o_pc` = `0x0`, `0x4`, `0x8`, `0xC`; `o_flush = 0`.
- **BEQ taken**: `o_pc = 0x20`, `i_pc_ex = 0x18`, `i_imm = 0x40`, `funct3 = 000`, `equal = 1` → `o_taken = 1` and `o_flush = 1` that cycle. Next cycle `o_pc = 0x58` with state REDIRECT; a branch asserted during REDIRECT is ignored; `o_br_total = 1`, `o_br_taken = 1`.
- **BGEU not taken**: `funct3 = 111`, `less = 1` → `o_br_un = 1`, `o_taken = 0`, PC advances by 4; `o_br_total` increments and `o_br_taken` does not.
- **JALR LSB clear plus stall**: `rs1 = 0x1001`, `imm = 0x4`, first with `i_stall = 1` for 2 cycles → PC holds and `o_flush = 0`. Then with `i_stall = 0` → `o_taken = 1`, next `o_pc = 0x1004`; counters unchanged.
- **Misaligned trap**: JAL with `i_pc_ex = 0x100`, `i_imm = 0x6` → `o_misaligned = 1` from the next cycle; `o_pc` frozen and `o_flush = 1` for 5+ cycles while further branches are ignored. Asserting `i_reset` low → `o_pc = RESET_PC`, `o_misaligned = 0`.
- **Counter wrap**: `CNT_W = 4`, 17 taken BNE branches, each followed by its REDIRECT cycle → `o_br_total = 1`, `o_br_taken = 1`.
